// File: rtl/aes_pkg.sv
// Shared AES definitions: round-count helper, widths, FSM encoding, S-box tables and GF(2^8) arithmetic.
package aes_pkg;
  localparam int BLOCK_W = 128;
  localparam int RK_W    = 128;

  typedef enum logic [1:0] {IDLE, ROUND, HOLD} fsm_t;

  function automatic int nr_of(input int nk);
    return nk + 6;
  endfunction

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  // The inverse table is derived from SBOX at elaboration so the two can never disagree.
  function automatic logic [0:255][7:0] invert_sbox();
    logic [0:255][7:0] t;
    t = '0;
    for (int i = 0; i < 256; i++) t[SBOX[i]] = 8'(i);
    return t;
  endfunction

  localparam logic [0:255][7:0] INV_SBOX = invert_sbox();

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/aes_round_unit.sv
// One combinational AES round, forward or inverse ordering; 'last' drops the (Inv)MixColumns step.
module aes_round_unit import aes_pkg::*; (
  input  logic [BLOCK_W-1:0] state,
  input  logic [RK_W-1:0]    rk,
  input  logic               dec,
  input  logic               last,
  output logic [BLOCK_W-1:0] round_out
);
  logic [7:0] b [16];
  logic [7:0] s [16];
  logic [7:0] m [16];
  logic [7:0] a0, a1, a2, a3, y0, y1, y2, y3;

  always_comb begin
    a0 = '0; a1 = '0; a2 = '0; a3 = '0;
    y0 = '0; y1 = '0; y2 = '0; y3 = '0;
    round_out = '0;
    for (int i = 0; i < 16; i++) b[i] = state[127-8*i -: 8];
    // Byte substitution and row shifting commute, so both orderings share one pass.
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        s[r+4*c] = dec ? INV_SBOX[b[r+4*((c+4-r)%4)]] : SBOX[b[r+4*((c+r)%4)]];
    for (int i = 0; i < 16; i++) m[i] = s[i] ^ (dec ? rk[127-8*i -: 8] : 8'h00);
    for (int c = 0; c < 4; c++) begin
      a0 = m[4*c]; a1 = m[4*c+1]; a2 = m[4*c+2]; a3 = m[4*c+3];
      if (last) begin
        y0 = a0; y1 = a1; y2 = a2; y3 = a3;
      end else if (dec) begin
        y0 = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
        y1 = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
        y2 = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
        y3 = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
      end else begin
        y0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        y1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        y2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        y3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      round_out[127-32*c -: 32] = {y0, y1, y2, y3} ^ (dec ? 32'h0 : rk[127-32*c -: 32]);
    end
  end
endmodule

// File: rtl/keyExpansion.sv
// Combinational AES key schedule; round keys packed MSB-first, rk[0] in the top 128 bits.
module keyExpansion import aes_pkg::*; #(
  parameter int Nk = 4,
  parameter int Nr = Nk + 6
) (
  input  logic [32*Nk-1:0]       key,
  output logic [128*(Nr+1)-1:0]  keySched
);
  localparam int NW = 4 * (Nr + 1);

  logic [31:0] w [NW];
  logic [31:0] t;
  logic [7:0]  rc;

  always_comb begin
    rc = 8'h01;
    t  = '0;
    for (int i = 0; i < Nk; i++) w[i] = key[32*Nk-1-32*i -: 32];
    for (int i = Nk; i < NW; i++) begin
      t = w[i-1];
      if (i % Nk == 0) begin
        t  = {SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]], SBOX[t[31:24]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end else if (Nk > 6 && i % Nk == 4) begin
        t = {SBOX[t[31:24]], SBOX[t[23:16]], SBOX[t[15:8]], SBOX[t[7:0]]};
      end
      w[i] = w[i-Nk] ^ t;
    end
    keySched = '0;
    for (int i = 0; i < NW; i++) keySched[128*(Nr+1)-1-32*i -: 32] = w[i];
  end
endmodule

// File: rtl/aes_iterative_engine.sv
// Iterative AES-128/192/256 encrypt/decrypt engine, one round per clock, valid/ready on key, input and output.
module aes_iterative_engine import aes_pkg::*; #(
  parameter  int Nk = 4,
  localparam int Nr = nr_of(Nk),
  localparam int N  = 32 * Nk
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N-1:0]       key,
  input  logic               key_valid,
  output logic               key_ready,
  input  logic [BLOCK_W-1:0] in,
  input  logic               mode,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [BLOCK_W-1:0] out,
  output logic               out_valid,
  input  logic               out_ready
);
  fsm_t                    fsm, fsm_nxt;
  logic [3:0]              round_cnt, rk_idx;
  logic [BLOCK_W-1:0]      state, round_out, rk_first;
  logic [N-1:0]            key_reg;
  logic                    key_loaded, mode_reg, last;
  logic [RK_W*(Nr+1)-1:0]  key_sched;
  logic [RK_W-1:0]         rk_arr [Nr+1];

  keyExpansion #(.Nk(Nk), .Nr(Nr)) u_kexp (.key(key_reg), .keySched(key_sched));

  for (genvar i = 0; i <= Nr; i++) begin : g_rk
    assign rk_arr[i] = key_sched[RK_W*(Nr-i) +: RK_W];
  end

  assign last     = (round_cnt == 4'(Nr));
  assign rk_idx   = mode_reg ? 4'(Nr) - round_cnt : round_cnt;
  assign rk_first = mode ? rk_arr[Nr] : rk_arr[0];

  aes_round_unit u_round (
    .state, .rk(rk_arr[rk_idx]), .dec(mode_reg), .last, .round_out
  );

  // A key offer blocks the block handshake so a block never sees a half-loaded key.
  assign key_ready = (fsm == IDLE);
  assign in_ready  = (fsm == IDLE) && key_loaded && !key_valid;

  always_ff @(posedge clk) begin
    if (!rst) fsm <= IDLE;
    else      fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (in_valid && in_ready) fsm_nxt = ROUND;
      ROUND:   if (last) fsm_nxt = HOLD;
      HOLD:    if (out_ready) fsm_nxt = IDLE;
      default: fsm_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      round_cnt  <= '0;
      state      <= '0;
      out        <= '0;
      out_valid  <= 1'b0;
      key_loaded <= 1'b0;
      key_reg    <= '0;
      mode_reg   <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (key_valid) begin
            key_reg    <= key;
            key_loaded <= 1'b1;
          end
          if (in_valid && in_ready) begin
            mode_reg  <= mode;
            state     <= in ^ rk_first;
            round_cnt <= 4'd1;
          end
        end
        ROUND: begin
          if (last) begin
            out       <= round_out;
            out_valid <= 1'b1;
            round_cnt <= '0;
          end else begin
            state     <= round_out;
            round_cnt <= round_cnt + 4'd1;
          end
        end
        HOLD:    if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_aes_iterative_engine.sv
// Bench for aes_iterative_engine: Nk=4/6/8 instances checked against FIPS-197 vectors and a byte-level AES model.
module tb_aes_iterative_engine;
  localparam logic [127:0] PT     = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT192  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] CT256  = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [127:0] key4;
  logic [191:0] key6;
  logic [255:0] key8;
  logic         kv [3], kr [3], iv [3], ir [3], md [3], ov [3], ordy [3];
  logic [127:0] din [3], dout [3];

  aes_iterative_engine #(.Nk(4)) u_aes128 (.clk, .rst, .key(key4), .key_valid(kv[0]), .key_ready(kr[0]),
    .in(din[0]), .mode(md[0]), .in_valid(iv[0]), .in_ready(ir[0]), .out(dout[0]), .out_valid(ov[0]), .out_ready(ordy[0]));
  aes_iterative_engine #(.Nk(6)) u_aes192 (.clk, .rst, .key(key6), .key_valid(kv[1]), .key_ready(kr[1]),
    .in(din[1]), .mode(md[1]), .in_valid(iv[1]), .in_ready(ir[1]), .out(dout[1]), .out_valid(ov[1]), .out_ready(ordy[1]));
  aes_iterative_engine #(.Nk(8)) u_aes256 (.clk, .rst, .key(key8), .key_valid(kv[2]), .key_ready(kr[2]),
    .in(din[2]), .mode(md[2]), .in_valid(iv[2]), .in_ready(ir[2]), .out(dout[2]), .out_valid(ov[2]), .out_ready(ordy[2]));

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] sb [256];
  logic [7:0] isb [256];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Reference AES on a byte array (index row + 4*col); key right-aligned in k.
  function automatic logic [127:0] ref_aes(input logic [255:0] k, input int nk, input logic [127:0] blk, input bit dec);
    logic [31:0] w [60];
    logic [31:0] v;
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  cf [4];
    logic [7:0]  rc, acc;
    logic [127:0] res;
    int nr;
    nr = nk + 6;
    rc = 8'h01;
    for (int i = 0; i < 4*(nr+1); i++) begin
      if (i < nk) w[i] = k[32*(nk-i)-1 -: 32];
      else begin
        v = w[i-1];
        if (i % nk == 0) begin
          v = {v[23:0], v[31:24]};
          v = {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
          v[31:24] = v[31:24] ^ rc;
          rc = gm(rc, 8'h02);
        end else if (nk == 8 && i % nk == 4)
          v = {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
        w[i] = w[i-nk] ^ v;
      end
    end
    for (int i = 0; i < 16; i++) s[i] = blk[127-8*i -: 8];
    if (dec) cf = '{8'd14, 8'd11, 8'd13, 8'd9};
    else     cf = '{8'd2, 8'd3, 8'd1, 8'd1};
    if (!dec) begin
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= nr; r++) begin
        for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
        for (int rr = 0; rr < 4; rr++) for (int c = 0; c < 4; c++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
        s = t;
        if (r < nr) begin
          for (int c = 0; c < 4; c++) for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j-i+4)%4], s[4*c+j]);
            t[4*c+i] = acc;
          end
          s = t;
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
      end
    end else begin
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*nr+i/4][31-8*(i%4) -: 8];
      for (int r = nr - 1; r >= 0; r--) begin
        for (int rr = 0; rr < 4; rr++) for (int c = 0; c < 4; c++) t[rr+4*((c+rr)%4)] = s[rr+4*c];
        s = t;
        for (int i = 0; i < 16; i++) s[i] = isb[s[i]];
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r+i/4][31-8*(i%4) -: 8];
        if (r > 0) begin
          for (int c = 0; c < 4; c++) for (int i = 0; i < 4; i++) begin
            acc = '0;
            for (int j = 0; j < 4; j++) acc = acc ^ gm(cf[(j-i+4)%4], s[4*c+j]);
            t[4*c+i] = acc;
          end
          s = t;
        end
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [255:0] rnd256();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic drive_key(input int d, input logic [255:0] k);
    case (d)
      0:       key4 = k[127:0];
      1:       key6 = k[191:0];
      default: key8 = k;
    endcase
  endtask

  task automatic load_key(input int d, input logic [255:0] k);
    int n;
    drive_key(d, k);
    kv[d] = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!kr[d] && n < 50);
    chk("key_ready", kr[d], 1'b1);
    @(posedge clk); #1 kv[d] = 1'b0;
  endtask

  // Offers a block, returns result, cycles from accept edge to out_valid, and stall cycles before accept.
  task automatic run_block(input int d, input logic [127:0] blk, input logic m, input bit toggle,
                           output logic [127:0] res, output int lat, output int waits);
    din[d] = blk; md[d] = m; iv[d] = 1'b1;
    waits = 0;
    do begin @(negedge clk); waits++; end while (!ir[d] && waits < 50);
    chk("in_ready_wait", ir[d], 1'b1);
    @(posedge clk); #1 iv[d] = 1'b0;
    lat = 0;
    while (!ov[d] && lat < 40) begin
      if (toggle) begin
        drive_key(d, rnd256()); kv[d] = 1'(($urandom)); md[d] = ~md[d];
        din[d] = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1 lat++;
    end
    kv[d] = 1'b0;
    chk("out_valid_wait", ov[d], 1'b1);
    res = dout[d];
  endtask

  function automatic logic [255:0] seq_key(input int nk);
    logic [255:0] k;
    k = '0;
    for (int i = 0; i < 4*nk; i++) k[8*(4*nk-1-i) +: 8] = 8'(i);
    return k;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] inv, af;
    logic [127:0] res, exp_ct [3];
    logic [255:0] cur_key [3], k2;
    int lat, waits, d, nk;
    logic m;
    bit tg;

    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      af = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = af;
      isb[af] = 8'(x);
    end
    exp_ct = '{CT128, CT192, CT256};

    rst = 1'b0; key4 = '0; key6 = '0; key8 = '0;
    for (int i = 0; i < 3; i++) begin
      kv[i] = 1'b0; iv[i] = 1'b0; md[i] = 1'b0; ordy[i] = 1'b1; din[i] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", ov[0], 1'b0);
    chk("rst_out", dout[0], '0);
    chk("rst_key_ready", kr[0], 1'b1);
    chk("rst_in_ready", ir[0], 1'b0);
    @(posedge clk); #1 rst = 1'b1;

    // Block offered before any key: must stall in IDLE.
    iv[0] = 1'b1; din[0] = PT;
    repeat (3) begin @(negedge clk); chk("nokey_in_ready", ir[0], 1'b0); end
    @(posedge clk); #1 iv[0] = 1'b0;
    @(negedge clk); chk("nokey_still_idle", kr[0], 1'b1);

    for (int i = 0; i < 3; i++) begin
      nk = 4 + 2*i;
      cur_key[i] = seq_key(nk);
      load_key(i, cur_key[i]);
      run_block(i, PT, 1'b0, 1'b0, res, lat, waits);
      chk($sformatf("fips_enc_nk%0d", nk), res, exp_ct[i]);
      chk($sformatf("fips_lat_nk%0d", nk), lat, nk + 6);
      run_block(i, exp_ct[i], 1'b1, 1'b0, res, lat, waits);
      chk($sformatf("fips_dec_nk%0d", nk), res, PT);
      chk($sformatf("fips_spacing_nk%0d", nk), waits, 2);
    end

    for (int it = 0; it < 24; it++) begin
      d = int'($urandom_range(0, 2));
      nk = 4 + 2*d;
      if (it % 4 == 0) begin
        cur_key[d] = rnd256() & ((256'h1 << (32*nk)) - 256'h1);
        load_key(d, cur_key[d]);
      end
      res = {$urandom, $urandom, $urandom, $urandom};
      m = 1'($urandom);
      tg = (it % 3 == 0);
      k2[127:0] = res;
      run_block(d, k2[127:0], m, tg, res, lat, waits);
      chk($sformatf("rand%0d_nk%0d_m%0d", it, nk, m), res, ref_aes(cur_key[d], nk, k2[127:0], m));
      chk($sformatf("rand%0d_lat", it), lat, nk + 6);
    end

    // Backpressure with a busy key port.
    cur_key[0] = seq_key(4);
    load_key(0, cur_key[0]);
    ordy[0] = 1'b0;
    run_block(0, PT, 1'b0, 1'b1, res, lat, waits);
    chk("bp_result", res, CT128);
    repeat (20) begin
      @(negedge clk);
      chk("bp_out", dout[0], CT128);
      chk("bp_out_valid", ov[0], 1'b1);
      chk("bp_in_ready", ir[0], 1'b0);
      chk("bp_key_ready", kr[0], 1'b0);
      @(posedge clk); #1 drive_key(0, rnd256()); kv[0] = 1'($urandom);
    end
    kv[0] = 1'b0; ordy[0] = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_release_valid", ov[0], 1'b0);
    chk("bp_release_in_ready", ir[0], 1'b1);
    chk("bp_out_kept", dout[0], CT128);
    run_block(0, PT, 1'b0, 1'b0, res, lat, waits);
    chk("bp_key_unchanged", res, CT128);

    // Simultaneous key and block offer: key first, block on the following edge.
    repeat (2) @(posedge clk);
    #1;
    k2 = rnd256() & ((256'h1 << 128) - 256'h1);
    drive_key(0, k2); kv[0] = 1'b1; iv[0] = 1'b1; din[0] = PT; md[0] = 1'b0;
    @(negedge clk);
    chk("prio_in_ready", ir[0], 1'b0);
    chk("prio_key_ready", kr[0], 1'b1);
    @(posedge clk); #1 kv[0] = 1'b0;
    run_block(0, PT, 1'b0, 1'b0, res, lat, waits);
    chk("prio_wait", waits, 1);
    chk("prio_new_key", res, ref_aes(k2, 4, PT, 1'b0));

    // Reset in the middle of round 5.
    repeat (2) @(posedge clk);
    #1 iv[0] = 1'b1; din[0] = PT;
    @(negedge clk); chk("mid_accept_ready", ir[0], 1'b1);
    @(posedge clk); #1 iv[0] = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_out_valid", ov[0], 1'b0);
    chk("mid_rst_out", dout[0], '0);
    chk("mid_rst_in_ready", ir[0], 1'b0);
    repeat (15) begin @(negedge clk); chk("mid_rst_no_output", ov[0], 1'b0); end
    load_key(0, seq_key(4));
    run_block(0, PT, 1'b0, 1'b0, res, lat, waits);
    chk("mid_rst_reload", res, CT128);
    chk("mid_rst_reload_lat", lat, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_iterative_engine.md
Name: aes_iterative_engine

Overview:
- Parametrised successor to the single-mode iterative AES-128 encryptor: one round per clock, supports AES-128/192/256 (via Nk) and both encrypt and decrypt, selected per block.
- Valid/ready handshakes on key load, block input and block output replace the level-held start/done pair.
- The expanded key is computed once from a latched key register, so the key port need not stay stable while blocks are processed.
- Sits between the host-side block buffer and the mode/chaining logic.

Parameters:
- Nk, 4, key length in 32-bit words; legal values are 4, 6, 8.
- Nr, Nk+6, round count (10/12/14); derived, never overridden independently.
- N, 32*Nk, key width in bits.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- key  in  N  cipher key.
- key_valid  in  1  key offer.
- key_ready  out  1  key accepted when key_valid && key_ready at the clock edge.
- in  in  128  input block (plaintext or ciphertext).
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with `in`.
- in_valid  in  1  block offer.
- in_ready  out  1  block accepted when in_valid && in_ready at the clock edge.
- out  out  128  result block.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts `out`.

Behaviour:
- Reset (rst == 0 at an edge):
  - FSM goes to IDLE; round_cnt = 0; state = 0; out = 0; out_valid = 0.
  - key_loaded = 0; key_reg = 0.
  - Any block in flight is dropped; no output is produced for it.
- Round-key indexing: keySched is keyExpansion(Nk, Nr) applied to key_reg, packed MSB-first. rk[i] = keySched[128*(Nr+1)-1-128*i -: 128].
- FSM states: IDLE, ROUND, HOLD.
- Ready signals (combinational from registers and inputs):
  - key_ready = (fsm == IDLE).
  - in_ready = (fsm == IDLE) && key_loaded && !key_valid. A simultaneous key offer wins; the block waits one cycle.
- IDLE:
  - Key handshake: key_reg <= key; key_loaded <= 1.
  - Block handshake:
    - mode_reg <= mode.
    - state <= in ^ rk[0] for encrypt, in ^ rk[Nr] for decrypt.
    - round_cnt <= 1; fsm <= ROUND.
- ROUND, round r = round_cnt (1..Nr):
  - Encrypt: SubBytes, ShiftRows, MixColumns (skipped when r == Nr), then XOR rk[r].
  - Decrypt: InvShiftRows, InvSubBytes, XOR rk[Nr-r], then InvMixColumns (skipped when r == Nr).
  - If r < Nr: state <= round_out; round_cnt <= r+1.
  - If r == Nr: out <= round_out; out_valid <= 1; round_cnt <= 0; fsm <= HOLD.
- HOLD:
  - out and out_valid are held stable until out_ready.
  - On out_ready: out_valid <= 0; fsm <= IDLE. out keeps its last value.
  - key_ready and in_ready are low in HOLD.
- Latency and throughput:
  - Block accepted at edge k -> out_valid high after edge k+Nr.
  - Minimum spacing between accepts is Nr+2 cycles (out_ready tied high).
- Boundary conditions:
  - key_valid while busy: ignored; key_ready is low.
  - in_valid before any key has been loaded: stalls; in_ready is low.
  - mode changing mid-block: no effect; only mode_reg is used.
  - out_ready asserted while out_valid is low: no effect.
- round_cnt is 4 bits wide; it never exceeds Nr <= 14.

Decomposition:
- Shared package aes_pkg:
  - Function nr_of(Nk).
  - Constants: BLOCK_W = 128, RK_W = 128.
  - FSM state encodings IDLE/ROUND/HOLD.
  - Sbox and inverse-Sbox tables, and the GF(2^8) xtime/mul helpers.
- Existing keyExpansion #(Nk, Nr) is reused, driven from key_reg.
- One natural sub-module: aes_round_unit.
  - Combinational.
  - Inputs: state, rk, dec, last. Output: round_out.
  - Implements both round orderings above.

Test Plan:
- AES-128 encrypt:
  - key = 000102030405060708090a0b0c0d0e0f, in = 00112233445566778899aabbccddeeff, mode = 0.
  - Required: out = 69c4e0d86a7b0430d8cdb78070b4c55a; out_valid rises exactly 10 cycles after the accept edge.
- AES-128 decrypt: same key, in = 69c4e0d86a7b0430d8cdb78070b4c55a, mode = 1 -> out = 00112233445566778899aabbccddeeff.
- Nk=6 and Nk=8 builds:
  - Key bytes 00..17 (Nk=6) / 00..1f (Nk=8), same plaintext.
  - Required: out = dda97ca4864cdfe06eaf70a0ec0d7191 after 12 cycles / 8ea2b7ca516745bfeafc49904b496089 after 14 cycles.
  - Decrypting each ciphertext returns the plaintext.
- Backpressure and key-port independence:
  - Hold out_ready = 0 for 20 cycles: out and out_valid stay stable; in_ready and key_ready stay low.
  - The key port toggles mid-block: result unchanged.
  - Raise out_ready: one transfer, then in_ready returns high.
- Priority and stall rules:
  - in_valid before any key load -> no accept.
  - key_valid and in_valid together in IDLE -> key accepted first, block accepted next cycle, encrypted with the new key.
- Reset mid-operation:
  - Drive rst = 0 at round 5 of a block.
  - Required: out_valid = 0, out = 0, in_ready = 0 (no key loaded).
  - Reload key and block -> correct FIPS vector result.
